// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : fetch-sequencer handshake bundle (hazard/branch/PC reg)
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int PC_WIDTH = 9
);
  logic                stall;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic                halt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] npc;
  logic                le_pc;
  logic                le_npc;
  logic                fetch_valid;
  logic                halted;

  // master: the sequencer itself; slave: the pipeline around it
  modport master (
    input  stall, redirect, target, halt,
    output pc, npc, le_pc, le_npc, fetch_valid, halted
  );

  modport slave (
    output stall, redirect, target, halt,
    input  pc, npc, le_pc, le_npc, fetch_valid, halted
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : fetch PC / delay-slot nPC owner with redirect and halt
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                     PC_WIDTH = 9,
  parameter int                     INC      = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pc_sequencer_if.master   bus
);

  localparam logic [PC_WIDTH-1:0] c_inc        = PC_WIDTH'(INC);
  localparam logic [PC_WIDTH-1:0] c_reset_npc  = RESET_PC + c_inc;
  localparam logic [PC_WIDTH-1:0] c_align_mask = ~(PC_WIDTH'(3));

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [PC_WIDTH-1:0] pc_q,       pc_d;
  logic [PC_WIDTH-1:0] npc_q,      npc_d;
  logic                pend_q,     pend_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic [PC_WIDTH-1:0] w_target_aligned;
  logic [PC_WIDTH-1:0] w_tgt;
  logic                w_advance;

  assign w_target_aligned = bus.target & c_align_mask;
  // A live redirect takes priority over one latched during a stall
  assign w_tgt            = bus.redirect ? w_target_aligned : pend_tgt_q;

  // Enables depend only on state and stall, never on target
  assign w_advance        = (state_q == ST_RUN) && !bus.stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      npc_q      <= c_reset_npc;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (w_advance) begin
          pc_d   = npc_q;
          npc_d  = (bus.redirect || pend_q) ? w_tgt : (npc_q + c_inc);
          pend_d = 1'b0;
          if (bus.halt) begin
            state_d = ST_HALT;
          end
        end else if (bus.redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = w_target_aligned;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.npc         = npc_q;
  assign bus.le_pc       = w_advance;
  assign bus.le_npc      = w_advance;
  assign bus.fetch_valid = (state_q == ST_RUN);
  assign bus.halted      = (state_q == ST_HALT);

endmodule

`default_nettype wire
